id_hazard_unit: RTL and testbench

Pipeline hazard and stall controller for the five-stage RV32I core. It sits beside the ID-stage branch/JALR forwarding logic and handles the hazards that forwarding cannot cover: load-use, and branch/JALR operands whose producers are not yet ready. It drives PC/IF-ID write enables, ID/EX bubble insertion and the IF/ID flush. A small state machine holds multi-cycle stall decisions, and an external memory wait freezes the whole pipe.

---
 rtl/id_hazard_unit.sv | 192 +++++++++++++++++++
 tb/tb_id_hazard_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_hazard_unit.sv
// id_hazard_unit
// Load-use / branch-operand hazard detection and stall control for the ID
// stage of the five-stage RV32I pipeline. Generates PC and IF/ID write
// enables, ID/EX bubble insertion, IF/ID flush and a whole-pipe freeze
// while external memory is not ready.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   ID_opcode, ID_ReadRegNum1/2   instruction in ID: opcode, rs1, rs2
//   EX_cntl_RegWrite/MemRead      EX-stage write-back / load flags
//   EX_WriteRegNum                EX-stage rd
//   MEM_cntl_RegWrite/MemRead     MEM-stage write-back / load flags
//   MEM_WriteRegNum               MEM-stage rd
//   ID_BranchTaken                taken branch / JAL / JALR resolved in ID
//   EXT_Stall                     instruction or data memory not ready
//   PC_Write, IF_ID_Write         load enables (combinational)
//   ID_EX_Bubble                  insert NOP into ID/EX (combinational)
//   IF_ID_Flush                   zero IF/ID on the next edge (combinational)
//   Pipe_Freeze                   hold ID/EX, EX/MEM, MEM/WB (combinational)
//   Stall_Count                   stall-cycle counter, only when the
//                                 HAZARD_PERF_CNT_EN macro is defined
module id_hazard_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  ID_opcode,
    input  logic [4:0]  ID_ReadRegNum1,
    input  logic [4:0]  ID_ReadRegNum2,
    input  logic        EX_cntl_RegWrite,
    input  logic        EX_cntl_MemRead,
    input  logic [4:0]  EX_WriteRegNum,
    input  logic        MEM_cntl_RegWrite,
    input  logic        MEM_cntl_MemRead,
    input  logic [4:0]  MEM_WriteRegNum,
    input  logic        ID_BranchTaken,
    input  logic        EXT_Stall,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        ID_EX_Bubble,
    output logic        IF_ID_Flush,
    output logic        Pipe_Freeze
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] Stall_Count
`endif
);

    localparam int unsigned CNT_W  = 2;
    localparam int unsigned NEED_W = 2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NEED_W-1:0]   need_c;
    logic                uses_rs1_c, uses_rs2_c, is_ctl_c;
    logic                ex_match_c, mem_match_c;
    logic                stall_c;

    // Source-operand usage decode for the instruction in ID
    always_comb begin
        uses_rs1_c = !((ID_opcode == OP_LUI) || (ID_opcode == OP_AUIPC) ||
                       (ID_opcode == OP_JAL));
        uses_rs2_c = (ID_opcode == OP_BRANCH) || (ID_opcode == OP_STORE) ||
                     (ID_opcode == OP_RTYPE);
        is_ctl_c   = (ID_opcode == OP_BRANCH) || (ID_opcode == OP_JALR);
    end

    // Producer matches against the EX and MEM destination registers (x0 never matches)
    always_comb begin
        ex_match_c  = EX_cntl_RegWrite &&
                      ((uses_rs1_c && (ID_ReadRegNum1 != 5'd0) &&
                        (ID_ReadRegNum1 == EX_WriteRegNum)) ||
                       (uses_rs2_c && (ID_ReadRegNum2 != 5'd0) &&
                        (ID_ReadRegNum2 == EX_WriteRegNum)));
        mem_match_c = MEM_cntl_RegWrite &&
                      ((uses_rs1_c && (ID_ReadRegNum1 != 5'd0) &&
                        (ID_ReadRegNum1 == MEM_WriteRegNum)) ||
                       (uses_rs2_c && (ID_ReadRegNum2 != 5'd0) &&
                        (ID_ReadRegNum2 == MEM_WriteRegNum)));
    end

    // Required stall cycles; the two-cycle case dominates the one-cycle cases
    always_comb begin
        need_c = NEED_W'(0);
        if (ex_match_c && EX_cntl_MemRead && is_ctl_c) begin
            need_c = NEED_W'(2);
        end else if ((ex_match_c && EX_cntl_MemRead) ||
                     (ex_match_c && is_ctl_c) ||
                     (mem_match_c && MEM_cntl_MemRead && is_ctl_c)) begin
            need_c = NEED_W'(1);
        end
    end

    // A stall cycle is any STALL-state cycle or a RUN cycle with an open hazard
    assign stall_c = (state_q == ST_STALL) || (need_c != NEED_W'(0));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            cnt_q   <= CNT_W'(0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; EXT_Stall holds state and counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!EXT_Stall) begin
            case (state_q)
                ST_RUN: begin
                    if (need_c == NEED_W'(2)) begin
                        state_d = ST_STALL;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_STALL: begin
                    // Saturate at zero so a stray cnt of 0 still exits STALL
                    cnt_d = (cnt_q == CNT_W'(0)) ? CNT_W'(0) : cnt_q - CNT_W'(1);
                    if (cnt_d == CNT_W'(0)) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_W'(0);
                end
            endcase
        end
    end

    // Output decode; priority: reset, external freeze, stall, normal flow
    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        IF_ID_Flush  = 1'b0;
        Pipe_Freeze  = 1'b0;
        if (!reset_n) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (EXT_Stall) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            Pipe_Freeze  = 1'b1;
        end else if (stall_c) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else begin
            IF_ID_Flush  = ID_BranchTaken;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    // Counts stall cycles that actually advance (not frozen); wraps naturally
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (stall_c && !EXT_Stall) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cnt_q <= 32'd0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign Stall_Count = perf_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed bench for id_hazard_unit. Expected output vectors
// {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze} are queued
// when a step is driven and popped/compared mid-cycle.
module tb_id_hazard_unit;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    localparam logic [4:0] E_RUN  = 5'b11000;
    localparam logic [4:0] E_RUNF = 5'b11010;
    localparam logic [4:0] E_STL  = 5'b00100;
    localparam logic [4:0] E_FRZ  = 5'b00001;
    localparam logic [4:0] E_RST  = 5'b00100;

    logic        clk;
    logic        reset_n;
    logic [6:0]  ID_opcode;
    logic [4:0]  ID_ReadRegNum1, ID_ReadRegNum2;
    logic        EX_cntl_RegWrite, EX_cntl_MemRead;
    logic [4:0]  EX_WriteRegNum;
    logic        MEM_cntl_RegWrite, MEM_cntl_MemRead;
    logic [4:0]  MEM_WriteRegNum;
    logic        ID_BranchTaken, EXT_Stall;
    logic        PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] Stall_Count;
`endif

    typedef struct {
        logic [4:0] exp;
        string      tag;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    id_hazard_unit dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ID_opcode         (ID_opcode),
        .ID_ReadRegNum1    (ID_ReadRegNum1),
        .ID_ReadRegNum2    (ID_ReadRegNum2),
        .EX_cntl_RegWrite  (EX_cntl_RegWrite),
        .EX_cntl_MemRead   (EX_cntl_MemRead),
        .EX_WriteRegNum    (EX_WriteRegNum),
        .MEM_cntl_RegWrite (MEM_cntl_RegWrite),
        .MEM_cntl_MemRead  (MEM_cntl_MemRead),
        .MEM_WriteRegNum   (MEM_WriteRegNum),
        .ID_BranchTaken    (ID_BranchTaken),
        .EXT_Stall         (EXT_Stall),
        .PC_Write          (PC_Write),
        .IF_ID_Write       (IF_ID_Write),
        .ID_EX_Bubble      (ID_EX_Bubble),
        .IF_ID_Flush       (IF_ID_Flush),
        .Pipe_Freeze       (Pipe_Freeze)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .Stall_Count       (Stall_Count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_id(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2);
        ID_opcode      = op;
        ID_ReadRegNum1 = r1;
        ID_ReadRegNum2 = r2;
    endtask

    task automatic set_ex(input logic rw, input logic mr, input logic [4:0] rd);
        EX_cntl_RegWrite = rw;
        EX_cntl_MemRead  = mr;
        EX_WriteRegNum   = rd;
    endtask

    task automatic set_mem(input logic rw, input logic mr, input logic [4:0] rd);
        MEM_cntl_RegWrite = rw;
        MEM_cntl_MemRead  = mr;
        MEM_WriteRegNum   = rd;
    endtask

    // Called 1 ns after a rising edge: queue expectation, check at mid-cycle, advance
    task automatic step(input logic bt, input logic ext, input logic [4:0] exp, input string tag);
        sb_t e;
        sb_t got;
        logic [4:0] obs;
        ID_BranchTaken = bt;
        EXT_Stall      = ext;
        e.exp = exp;
        e.tag = tag;
        sb.push_back(e);
        #4;
        obs = {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze};
        n_checks++;
        if (sb.size() == 0) begin
            $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
        end else begin
            got = sb.pop_front();
            assert (obs === got.exp) n_pass++;
            else $error("FAIL %s: observed %b expected %b", got.tag, obs, got.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hazards();
        set_id(OP_RTYPE, 5'd2, 5'd3);
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        clear_hazards();
        ID_BranchTaken = 1'b0;
        EXT_Stall      = 1'b0;
        #1;

        step(1'b0, 1'b0, E_RST, "reset_forced");
        reset_n = 1'b1;
        step(1'b0, 1'b0, E_RUN, "idle");

        // lw x5 in EX, beq x5,x0 in ID, branch taken
        set_id(OP_BRANCH, 5'd5, 5'd0);
        set_ex(1'b1, 1'b1, 5'd5);
        step(1'b1, 1'b0, E_STL, "ldbr_c1");
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b1, 5'd5);
        step(1'b1, 1'b0, E_STL, "ldbr_c2");
        set_mem(1'b0, 1'b0, 5'd0);
        step(1'b1, 1'b0, E_RUNF, "ldbr_c3_flush");

        // lw x7 in EX, add x1,x7,x2 in ID
        set_id(OP_RTYPE, 5'd7, 5'd2);
        set_ex(1'b1, 1'b1, 5'd7);
        step(1'b0, 1'b0, E_STL, "ldalu_c1");
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b1, 5'd7);
        step(1'b0, 1'b0, E_RUN, "ldalu_c2");
        set_mem(1'b0, 1'b0, 5'd0);

        // add x1,x2,x3 against lw x7
        set_id(OP_RTYPE, 5'd2, 5'd3);
        set_ex(1'b1, 1'b1, 5'd7);
        step(1'b0, 1'b0, E_RUN, "no_dep");

        // addi x0 in EX, beq x0,x0 in ID
        set_id(OP_BRANCH, 5'd0, 5'd0);
        set_ex(1'b1, 1'b0, 5'd0);
        step(1'b0, 1'b0, E_RUN, "x0_no_stall");

        // lui x5 against lw x5
        set_id(OP_LUI, 5'd5, 5'd5);
        set_ex(1'b1, 1'b1, 5'd5);
        step(1'b0, 1'b0, E_RUN, "lui_no_stall");

        // sw x9,0(x1) against lw x9: rs2 dependency
        set_id(OP_STORE, 5'd1, 5'd9);
        set_ex(1'b1, 1'b1, 5'd9);
        step(1'b0, 1'b0, E_STL, "store_rs2");
        set_ex(1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, E_RUN, "store_after");

        // jalr x1,0(x6) with add x6 in EX
        set_id(OP_JALR, 5'd6, 5'd6);
        set_ex(1'b1, 1'b0, 5'd6);
        step(1'b1, 1'b0, E_STL, "jalr_c1_noflush");
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b0, 5'd6);
        step(1'b1, 1'b0, E_RUNF, "jalr_c2_flush");
        set_mem(1'b0, 1'b0, 5'd0);

        // Load in MEM feeding a branch on rs2
        set_id(OP_BRANCH, 5'd1, 5'd8);
        set_mem(1'b1, 1'b1, 5'd8);
        step(1'b0, 1'b0, E_STL, "memld_br");
        set_mem(1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, E_RUN, "memld_after");

        // Reset pulsed while in STALL; forced outputs even with EXT_Stall high
        set_id(OP_BRANCH, 5'd5, 5'd0);
        set_ex(1'b1, 1'b1, 5'd5);
        step(1'b0, 1'b0, E_STL, "rst_pre_c1");
        reset_n = 1'b0;
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b1, 5'd5);
        step(1'b0, 1'b1, E_RST, "rst_in_stall");
        reset_n = 1'b1;
        clear_hazards();
        step(1'b0, 1'b0, E_RUN, "rst_release_run");

        // EXT_Stall on a frozen idle pipe
        step(1'b0, 1'b1, E_FRZ, "ext_idle");

        // Load-branch stall with three frozen cycles after the first stall cycle
        set_id(OP_BRANCH, 5'd5, 5'd0);
        set_ex(1'b1, 1'b1, 5'd5);
        step(1'b0, 1'b0, E_STL, "ext_c1");
        set_ex(1'b0, 1'b0, 5'd0);
        set_mem(1'b1, 1'b1, 5'd5);
        step(1'b0, 1'b1, E_FRZ, "ext_frz1");
        step(1'b0, 1'b1, E_FRZ, "ext_frz2");
        step(1'b0, 1'b1, E_FRZ, "ext_frz3");
        step(1'b0, 1'b0, E_STL, "ext_c2");
        set_mem(1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b0, E_RUN, "ext_run");

`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        assert (Stall_Count === 32'd2) n_pass++;
        else $error("FAIL stall_count: observed %0d expected 2", Stall_Count);
`endif

        if (sb.size() != 0) begin
            n_checks++;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
